fg_mask_classifier: RTL and testbench
=====================================

// Module: fg_mask_classifier
// PURPOSE
// - Downstream of background subtraction: per pixel, reads the accumulated model (sum S, sum-of-squares Q) from SRAM,
//   derives mean/variance, classifies the incoming gray pixel as foreground/background, streams a 1-bit mask out.
// - Feeds mask to VGA overlay / post-filter stages; uses the SRAM read slot only, never writes.
// PARAMETERS
// - H_MAX 640 : pixels per line;  V_MAX 480 : lines per frame;  ADDR_W 20 : SRAM word address width
// - K_SQ 36 : k^2 in quarter units (36 -> k=3);  MIN_THR 16 : floor on threshold (d^2 units)
// PORTS
// - i_clk  in 1 : system clock (100 MHz);  i_rst  in 1 : synchronous, active-high reset
// - i_valid in 1 / o_ready out 1 / i_gray in 8 / i_sof in 1 : upstream gray stream; i_sof marks pixel (0,0)
// - i_model_ready in 1 : model holds >=1 full frame (init done from background subtraction)
// - o_sram_rd out 1 / o_sram_addr out ADDR_W / i_sram_dq in 16 : SRAM read; data valid cycle after address
// - o_valid out 1 / i_ready in 1 : downstream handshake;  o_fg out 1 : 1 = foreground
// - o_gray out 8 : pixel passthrough;  o_h out 10 / o_v out 10 : coordinates of output pixel
// BEHAVIOUR
// - Reset (any state, mid-op included): state=IDLE, h=v=0, o_valid=0, o_fg=0, o_sram_rd=0, o_sram_addr=0, o_gray=0, o_h=o_v=0.
// - SRAM layout, pixel p=v*H_MAX+h: word 2p = Q[20:5] = E[x^2]; word 2p+1 = {Q[4:1], S[12:1]}; mean = word(2p+1)[11:4].
// - FSM: IDLE -> RD_A -> RD_B -> CALC -> OUT -> IDLE. o_ready=1 only in IDLE; accept on i_valid&&o_ready.
//   - IDLE accept: latch i_gray, h, v; if i_model_ready go RD_A else go OUT with o_fg=0 (no SRAM access).
//   - RD_A: o_sram_rd=1, addr=2p.  RD_B: o_sram_rd=1, addr=2p+1, capture dq as ex2.  CALC: dq = word B, compute, register result.
//   - OUT: o_valid=1; o_fg/o_gray/o_h/o_v stable until i_ready; on i_valid&&... i.e. o_valid&&i_ready -> IDLE.
// - Latency: accept cycle 0 -> o_valid cycle 4 (model ready) or cycle 1 (bypass). Peak rate 1 pixel / 5 cycles.
// - o_sram_rd=0 outside RD_A/RD_B; o_sram_addr holds last value.
// - Arithmetic (unsigned unless noted): m2 = mean*mean (16b); var = ex2 - m2 as 17b signed, clamp <0 to 0 (16b);
//   thr = max((var*K_SQ)>>2, MIN_THR) (22b); d = gray - mean signed 9b; o_fg = (d*d > thr) strict.
// - Counters advance on accept: h wraps H_MAX-1 -> 0 and increments v; v wraps V_MAX-1 -> 0 (address back to 0).
// - i_sof on an accepted beat forces that pixel to h=v=0 (counters resync); i_sof ignored when not accepted.
// - i_model_ready sampled only at accept; a change mid-pixel does not affect the pixel in flight.
// - i_valid while not IDLE: not accepted, upstream holds data (o_ready=0).
// STRUCTURE
// - Shared package bgs_pkg: H_MAX/V_MAX defaults, SRAM word-layout field constants (S/Q slices), FSM state enum.
// - Sub-module fg_threshold_calc (combinational): in gray, mean, ex2 -> out fg; holds clamp/threshold/compare math.
// - Top: FSM, pixel counters, address generation (p<<1 and (p<<1)+1), output registers.
// TESTING
// - Reset: hold i_rst 2 cycles mid-RD_B -> next cycle IDLE, o_valid=0, o_sram_rd=0, o_ready=1, next pixel h=v=0.
// - Bypass: i_model_ready=0, push gray=100 -> o_valid at cycle 1, o_fg=0, o_gray=100, o_sram_rd never asserted.
// - Classify at (h=5,v=2): addrs 2570 then 2571; wordA=10016, wordB=1600 (mean 100, var 16, thr 144):
//   gray=112 -> fg=0; gray=113 -> fg=1; gray=87 -> fg=1; gray=88 -> fg=0.
// - Clamp: wordA=9990, wordB=1600 -> var 0, thr=MIN_THR=16: gray=104 -> fg=0; gray=105 -> fg=1; gray=96 -> fg=0.
// - Wrap/sync: 307200 accepted pixels -> next pixel addr 0, h=v=0; i_sof on pixel at (300,100) -> that pixel reports (0,0).
// - Backpressure: i_ready=0 for 3 cycles in OUT -> o_valid/o_fg/o_gray/o_h/o_v stable, o_ready=0; i_ready=1 -> IDLE next cycle.

Source files
------------

// File: rtl/bgs_pkg.sv
// Shared definitions for the background-subtraction pipeline: frame size defaults,
// SRAM model word layout and the classifier state encoding.
package bgs_pkg;

  localparam int H_MAX_DEF = 640;
  localparam int V_MAX_DEF = 480;

  // Word A (even address) holds Q[20:5], i.e. E[x^2], in all 16 bits.
  localparam int WA_EX2_MSB = 15;
  localparam int WA_EX2_LSB = 0;

  // Word B (odd address) holds {Q[4:1], S[12:1]}; the mean is S[12:5].
  localparam int WB_Q_MSB    = 15;
  localparam int WB_Q_LSB    = 12;
  localparam int WB_MEAN_MSB = 11;
  localparam int WB_MEAN_LSB = 4;
  localparam int WB_S_LSB    = 0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_A,
    S_RD_B,
    S_CALC,
    S_OUT
  } state_t;

endpackage

// File: rtl/fg_threshold_calc.sv
// Combinational foreground decision: variance from E[x^2] and mean, k^2-scaled
// threshold with a floor, and a strict squared-distance comparison.
module fg_threshold_calc #(
  parameter int K_SQ    = 36,
  parameter int MIN_THR = 16
) (
  input  logic [7:0]  gray,
  input  logic [7:0]  mean,
  input  logic [15:0] ex2,
  output logic        fg
);

  logic [15:0]        m2;
  logic [16:0]        diff;
  logic [15:0]        var_c;
  logic [23:0]        prod;
  logic [21:0]        thr_raw;
  logic [21:0]        thr;
  logic signed [8:0]  d;
  logic signed [17:0] d_sq;

  // NOTE: every variable gets a value on every path through always_comb, so no latch is inferred.
  always_comb begin
    m2      = 16'(mean) * 16'(mean);
    diff    = {1'b0, ex2} - {1'b0, m2};
    // A negative variance is rounding noise from the accumulator; treat it as zero.
    var_c   = diff[16] ? '0 : diff[15:0];
    prod    = 24'(var_c) * 24'(K_SQ);
    thr_raw = prod[23:2];
    thr     = (thr_raw < 22'(MIN_THR)) ? 22'(MIN_THR) : thr_raw;
    d       = $signed({1'b0, gray}) - $signed({1'b0, mean});
    d_sq    = 18'(d) * 18'(d);
    fg      = (22'($unsigned(d_sq)) > thr);
  end

endmodule

// File: rtl/fg_mask_classifier.sv
// Per-pixel foreground classifier: reads the two model words for the pixel from
// SRAM, evaluates the threshold test and streams a registered 1-bit mask out.
module fg_mask_classifier
  import bgs_pkg::*;
#(
  parameter int H_MAX   = H_MAX_DEF,
  parameter int V_MAX   = V_MAX_DEF,
  parameter int ADDR_W  = 20,
  parameter int K_SQ    = 36,
  parameter int MIN_THR = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [7:0]        i_gray,
  input  logic              i_sof,
  input  logic              i_model_ready,
  output logic              o_sram_rd,
  output logic [ADDR_W-1:0] o_sram_addr,
  input  logic [15:0]       i_sram_dq,
  output logic              o_valid,
  input  logic              i_ready,
  output logic              o_fg,
  output logic [7:0]        o_gray,
  output logic [9:0]        o_h,
  output logic [9:0]        o_v
);

  localparam int PIX_N = H_MAX * V_MAX;
  localparam int PIX_W = $clog2(PIX_N);

  state_t           state;
  logic [9:0]       h_cnt, v_cnt;
  logic [PIX_W-1:0] p_cnt;
  logic [9:0]       cur_h, cur_v;
  logic [PIX_W-1:0] cur_p;
  logic             accept;
  logic [15:0]      ex2_q;
  logic             fg_calc;
  logic             unused_dq_bits;

  assign o_ready = (state == S_IDLE);

  // A start-of-frame beat resynchronises the counters on the pixel it arrives with.
  always_comb begin
    accept = i_valid && o_ready;
    cur_h  = i_sof ? '0 : h_cnt;
    cur_v  = i_sof ? '0 : v_cnt;
    cur_p  = i_sof ? '0 : p_cnt;
  end

  // Q[4:1] and the sub-mean bits of S are not needed for the decision.
  assign unused_dq_bits = ^{i_sram_dq[WB_Q_MSB:WB_Q_LSB], i_sram_dq[WB_MEAN_LSB-1:WB_S_LSB]};

  fg_threshold_calc #(
    .K_SQ    (K_SQ),
    .MIN_THR (MIN_THR)
  ) u_thr (
    .gray (o_gray),
    .mean (i_sram_dq[WB_MEAN_MSB:WB_MEAN_LSB]),
    .ex2  (ex2_q),
    .fg   (fg_calc)
  );

  // NOTE: ex2_q is pure datapath, always written before it is read, so it carries no reset.
  always_ff @(posedge i_clk) begin
    if (state == S_RD_B) ex2_q <= i_sram_dq[WA_EX2_MSB:WA_EX2_LSB];
  end

  // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= S_IDLE;
      h_cnt       <= '0;
      v_cnt       <= '0;
      p_cnt       <= '0;
      o_valid     <= 1'b0;
      o_fg        <= 1'b0;
      o_sram_rd   <= 1'b0;
      o_sram_addr <= '0;
      o_gray      <= '0;
      o_h         <= '0;
      o_v         <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            o_gray <= i_gray;
            o_h    <= cur_h;
            o_v    <= cur_v;
            if (cur_h == 10'(H_MAX - 1)) begin
              h_cnt <= '0;
              v_cnt <= (cur_v == 10'(V_MAX - 1)) ? '0 : cur_v + 10'd1;
            end else begin
              h_cnt <= cur_h + 10'd1;
              v_cnt <= cur_v;
            end
            p_cnt <= (cur_p == PIX_W'(PIX_N - 1)) ? '0 : cur_p + PIX_W'(1);
            if (i_model_ready) begin
              state       <= S_RD_A;
              o_sram_rd   <= 1'b1;
              o_sram_addr <= ADDR_W'({cur_p, 1'b0});
            end else begin
              state   <= S_OUT;
              o_fg    <= 1'b0;
              o_valid <= 1'b1;
            end
          end
        end
        S_RD_A: begin
          state       <= S_RD_B;
          o_sram_addr <= {o_sram_addr[ADDR_W-1:1], 1'b1};
        end
        S_RD_B: begin
          state     <= S_CALC;
          o_sram_rd <= 1'b0;
        end
        S_CALC: begin
          state   <= S_OUT;
          o_fg    <= fg_calc;
          o_valid <= 1'b1;
        end
        S_OUT: begin
          if (i_ready) begin
            state   <= S_IDLE;
            o_valid <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fg_mask_classifier.sv
// Randomised and directed bench for fg_mask_classifier against an integer reference
// model; a second, small-frame instance runs in lockstep to exercise frame wrap.
module tb_fg_mask_classifier;

  localparam int MH      = 640;
  localparam int MV      = 480;
  localparam int SH      = 8;
  localparam int SV      = 4;
  localparam int K_SQ    = 36;
  localparam int MIN_THR = 16;

  logic        clk;
  logic        i_rst;
  logic        i_valid;
  logic [7:0]  i_gray;
  logic        i_sof;
  logic        i_model_ready;
  logic        i_ready;

  logic        o_ready, o_sram_rd, o_valid, o_fg;
  logic [19:0] o_sram_addr;
  logic [15:0] dq;
  logic [7:0]  o_gray;
  logic [9:0]  o_h, o_v;

  logic        s_ready, s_rd, s_valid, s_fg;
  logic [19:0] s_addr;
  logic [15:0] sdq;
  logic [7:0]  s_gray;
  logic [9:0]  s_h, s_v;

  int n_checks = 0;
  int n_fail   = 0;
  int p_main   = 0;
  int p_small  = 0;

  logic [15:0] mem [int];

  fg_mask_classifier #(.H_MAX(MH), .V_MAX(MV), .ADDR_W(20), .K_SQ(K_SQ), .MIN_THR(MIN_THR)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready), .i_gray(i_gray),
    .i_sof(i_sof), .i_model_ready(i_model_ready), .o_sram_rd(o_sram_rd),
    .o_sram_addr(o_sram_addr), .i_sram_dq(dq), .o_valid(o_valid), .i_ready(i_ready),
    .o_fg(o_fg), .o_gray(o_gray), .o_h(o_h), .o_v(o_v)
  );

  fg_mask_classifier #(.H_MAX(SH), .V_MAX(SV), .ADDR_W(20), .K_SQ(K_SQ), .MIN_THR(MIN_THR)) dut_small (
    .i_clk(clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(s_ready), .i_gray(i_gray),
    .i_sof(i_sof), .i_model_ready(i_model_ready), .o_sram_rd(s_rd),
    .o_sram_addr(s_addr), .i_sram_dq(sdq), .o_valid(s_valid), .i_ready(i_ready),
    .o_fg(s_fg), .o_gray(s_gray), .o_h(s_h), .o_v(s_v)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [15:0] word_of(input logic [19:0] a);
    if (mem.exists(int'(a))) return mem[int'(a)];
    return 16'(a * 20'd40503) ^ 16'h5a5a;
  endfunction

  // SRAM: data for a read address appears the following cycle; garbage otherwise.
  always @(posedge clk) begin
    dq  <= o_sram_rd ? word_of(o_sram_addr) : 16'($urandom);
    sdq <= s_rd ? word_of(s_addr) : 16'($urandom);
  end

  // Reference decision straight from the model statistics.
  function automatic bit ref_fg(input int g, input int wa, input int wb);
    int mean, v, thr;
    mean = (wb / 16) % 256;
    v    = wa - mean * mean;
    if (v < 0) v = 0;
    thr = (v * K_SQ) / 4;
    if (thr < MIN_THR) thr = MIN_THR;
    return ((g - mean) * (g - mean)) > thr;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic prog(input int p, input int mean, input int vr);
    int wa;
    wa = mean * mean + vr;
    if (wa < 0) wa = 0;
    if (wa > 65535) wa = 65535;
    mem[2 * p]     = 16'(wa);
    mem[2 * p + 1] = {4'($urandom), 8'(mean), 4'($urandom)};
  endtask

  task automatic check_hold(input bit efg, input logic [7:0] g, input int pm, input bit sfg, input int ps);
    check("valid", o_valid, 1);
    check("busy_ready", o_ready, 0);
    check("rd_in_out", o_sram_rd, 0);
    check("fg", o_fg, efg);
    check("gray", o_gray, g);
    check("h", o_h, pm % MH);
    check("v", o_v, pm / MH);
    check("s_valid", s_valid, 1);
    check("s_fg", s_fg, sfg);
    check("s_h", s_h, ps % SH);
    check("s_v", s_v, ps / SH);
  endtask

  // Push one pixel, follow it to the output and check everything it produces.
  task automatic run_pixel(input logic [7:0] g, input logic sof, input logic mr, input int stall);
    int pm, ps, cyc, rd_n;
    logic [19:0] a0, a1, sa0;
    bit efg, sfg, s_seen;
    if (sof) begin
      p_main  = 0;
      p_small = 0;
    end
    pm  = p_main;
    ps  = p_small;
    efg = mr ? ref_fg(g, word_of(20'(2 * pm)), word_of(20'(2 * pm + 1))) : 1'b0;
    sfg = mr ? ref_fg(g, word_of(20'(2 * ps)), word_of(20'(2 * ps + 1))) : 1'b0;
    check("idle_ready", o_ready, 1);
    i_valid = 1'b1; i_gray = g; i_sof = sof; i_model_ready = mr; i_ready = (stall == 0);
    @(posedge clk); #1;
    p_main  = (pm + 1) % (MH * MV);
    p_small = (ps + 1) % (SH * SV);
    // Held or changed inputs while busy must not disturb the pixel in flight.
    i_sof = 1'b0; i_valid = 1'($urandom_range(0, 1)); i_gray = 8'($urandom);
    i_model_ready = 1'($urandom_range(0, 1));
    cyc = 1; rd_n = 0; a0 = '0; a1 = '0; sa0 = '0; s_seen = 1'b0;
    while (!o_valid && cyc < 12) begin
      if (o_sram_rd) begin
        if (rd_n == 0) a0 = o_sram_addr;
        else a1 = o_sram_addr;
        rd_n++;
      end
      if (s_rd && !s_seen) begin
        sa0 = s_addr;
        s_seen = 1'b1;
      end
      @(posedge clk); #1;
      cyc++;
    end
    check("latency", cyc, mr ? 4 : 1);
    check("rd_count", rd_n, mr ? 2 : 0);
    if (mr) begin
      check("addr_a", a0, 2 * pm);
      check("addr_b", a1, 2 * pm + 1);
      check("s_addr_a", sa0, 2 * ps);
    end
    repeat (stall) begin
      check_hold(efg, g, pm, sfg, ps);
      @(posedge clk); #1;
    end
    i_ready = 1'b1;
    check_hold(efg, g, pm, sfg, ps);
    @(posedge clk); #1;
    i_valid = 1'b0;
    check("valid_drop", o_valid, 0);
    check("back_idle", o_ready, 1);
  endtask

  initial begin
    int mean, g;
    i_rst = 1'b1; i_valid = 1'b0; i_gray = '0; i_sof = 1'b0; i_model_ready = 1'b0; i_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    i_rst = 1'b0;
    check("rst_valid", o_valid, 0);
    check("rst_fg", o_fg, 0);
    check("rst_rd", o_sram_rd, 0);
    check("rst_addr", o_sram_addr, 0);
    check("rst_gray", o_gray, 0);
    check("rst_h", o_h, 0);
    check("rst_v", o_v, 0);

    // Bypass: model not ready, no SRAM access, immediate output.
    run_pixel(8'd100, 1'b1, 1'b0, 0);

    // Random traffic with mixed model readiness, stalls and occasional resync.
    for (int i = 0; i < 300; i++) begin
      logic sof;
      sof  = ($urandom_range(0, 49) == 0);
      mean = $urandom_range(0, 255);
      prog(sof ? 0 : p_main, mean, int'($urandom_range(0, 600)) - 60);
      g = mean + int'($urandom_range(0, 80)) - 40;
      if (g < 0) g = 0;
      if (g > 255) g = 255;
      run_pixel(8'(g), sof, ($urandom_range(0, 9) != 0),
                ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);
    end

    // Reset held for two cycles while a pixel sits in RD_B.
    i_valid = 1'b1; i_gray = 8'd50; i_sof = 1'b0; i_model_ready = 1'b1; i_ready = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b0;
    @(posedge clk); #1;
    check("rdb_rd", o_sram_rd, 1);
    i_rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    i_rst = 1'b0;
    check("mid_rst_ready", o_ready, 1);
    check("mid_rst_valid", o_valid, 0);
    check("mid_rst_rd", o_sram_rd, 0);
    check("mid_rst_addr", o_sram_addr, 0);
    p_main  = 0;
    p_small = 0;
    run_pixel(8'd77, 1'b0, 1'b0, 0);

    // Backpressure for three cycles in OUT.
    run_pixel(8'd200, 1'b0, 1'b1, 3);

    // Walk to pixel (5,2) through bypass pixels, crossing a line wrap.
    run_pixel(8'($urandom), 1'b1, 1'b0, 0);
    while (p_main != 2 * MH + 5) run_pixel(8'($urandom), 1'b0, 1'b0, 0);
    for (int p = 2 * MH + 5; p < 2 * MH + 12; p++) begin
      mem[2 * p]     = (p < 2 * MH + 9) ? 16'd10016 : 16'd9990;
      mem[2 * p + 1] = 16'd1600;
    end
    run_pixel(8'd112, 1'b0, 1'b1, 0);
    run_pixel(8'd113, 1'b0, 1'b1, 0);
    run_pixel(8'd87,  1'b0, 1'b1, 0);
    run_pixel(8'd88,  1'b0, 1'b1, 0);
    run_pixel(8'd104, 1'b0, 1'b1, 0);
    run_pixel(8'd105, 1'b0, 1'b1, 0);
    run_pixel(8'd96,  1'b0, 1'b1, 0);

    // Start-of-frame mid-line forces that pixel to (0,0).
    run_pixel(8'd30, 1'b1, 1'b1, 0);
    run_pixel(8'd31, 1'b0, 1'b1, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
